// File: rtl/ddr3_traffic_checker_pkg.sv
// Shared state/pattern codes and LFSR feedback masks for the DDR3 traffic checker.
package ddr3_traffic_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        PAT_INCR = 2'd0,
        PAT_WALK = 2'd1,
        PAT_LFSR = 2'd2,
        PAT_INV  = 2'd3
    } pattern_e;

    // Bit masks of the feedback taps for a left-shifting Fibonacci LFSR (maximal length).
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/ddr3_traffic_checker_if.sv
// User-port command/response bundle between the traffic checker and the DDR3 controller.
interface ddr3_traffic_checker_if #(
    parameter int DQ = 16,
    parameter int AW = 18
);
    logic          write_enable;
    logic          read_enable;
    logic [AW-1:0] i_user_data_address;
    logic [DQ-1:0] i_user_data;
    logic          ctrl_ready;
    logic [DQ-1:0] o_user_data;
    logic          o_user_data_valid;

    modport master (
        output write_enable, read_enable, i_user_data_address, i_user_data,
        input  ctrl_ready, o_user_data, o_user_data_valid
    );

    modport slave (
        input  write_enable, read_enable, i_user_data_address, i_user_data,
        output ctrl_ready, o_user_data, o_user_data_valid
    );
endinterface

// File: rtl/ddr3_traffic_checker_pattern_gen.sv
// Word pattern source: load latches mode/seed (index 0), advance steps to the next index.
// Output is a mux over registered state, so it is stable until the next load/advance.
module ddr3_traffic_checker_pattern_gen
    import ddr3_traffic_checker_pkg::*;
#(
    parameter int DQ = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          advance_i,
    input  pattern_e      mode_i,
    input  logic [DQ-1:0] seed_i,
    output logic [DQ-1:0] word_o
);
    localparam logic [DQ-1:0] TAPS = DQ'(lfsr_taps(DQ));
    localparam logic [DQ-1:0] ONE  = DQ'(1);
    localparam int            SW   = $clog2(DQ);

    pattern_e      mode_q;
    logic [DQ-1:0] sum_q;
    logic [DQ-1:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= PAT_INCR;
            sum_q  <= '0;
            lfsr_q <= '0;
        end else if (load_i) begin
            mode_q <= mode_i;
            sum_q  <= seed_i;
            lfsr_q <= (seed_i == '0) ? '1 : seed_i;
        end else if (advance_i) begin
            sum_q  <= sum_q + ONE;
            lfsr_q <= {lfsr_q[DQ-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_comb begin
        word_o = sum_q;
        case (mode_q)
            PAT_INCR: word_o = sum_q;
            PAT_WALK: word_o = ONE << sum_q[SW-1:0];
            PAT_LFSR: word_o = lfsr_q;
            PAT_INV:  word_o = ~sum_q;
            default:  word_o = sum_q;
        endcase
    end
endmodule

// File: rtl/ddr3_traffic_checker.sv
// Write-then-read-back pattern checker: NUM_WORDS writes, then up to MAX_OUTSTANDING reads in flight,
// in-order compare; commands hold until ctrl_ready, error_count/done update 1 cycle after the response.
module ddr3_traffic_checker
    import ddr3_traffic_checker_pkg::*;
#(
    parameter int  DQ_BITWIDTH           = 16,
    parameter int  ADDRESS_BITWIDTH      = 15,
    parameter int  BANK_ADDRESS_BITWIDTH = 3,
    parameter int  NUM_WORDS             = 256,
    parameter int  MAX_OUTSTANDING       = 4,
    parameter int  ERR_CNT_BITWIDTH      = 16,
    localparam int AW                    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [DQ_BITWIDTH-1:0]      seed,
    input  logic [AW-1:0]               base_address,
    input  logic                        stop_on_error,
    ddr3_traffic_checker_if.master      mem,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ERR_CNT_BITWIDTH-1:0] error_count,
    output logic [AW-1:0]               first_error_address,
    output logic                        protocol_error,
    output logic [2:0]                  main_state
);
    localparam int                    CW       = $clog2(NUM_WORDS + 1);
    localparam int                    OW       = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0]         LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0]         N_WORDS  = CW'(NUM_WORDS);
    localparam logic [CW-1:0]         C_ONE    = CW'(1);
    localparam logic [OW-1:0]         MAX_OUT  = OW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]         A_ONE    = AW'(1);
    localparam logic [ERR_CNT_BITWIDTH-1:0] E_ONE = ERR_CNT_BITWIDTH'(1);

    state_e                      state_q;
    logic                        wr_en_q, rd_en_q, busy_q, done_q, pass_q, proto_q, abort_q;
    logic [AW-1:0]               base_q, addr_q, chk_addr_q, first_err_q;
    logic [CW-1:0]               issued_q, chk_idx_q;
    logic [OW-1:0]               out_q;
    logic [ERR_CNT_BITWIDTH-1:0] err_q;

    logic                        start_ok, wr_acc, rd_acc, chk_vld, spurious, mismatch, last_chk, abort_d;
    logic [CW-1:0]               issued_d;
    logic [OW-1:0]               out_d;
    logic [DQ_BITWIDTH-1:0]      cmd_word, chk_word;

    always_comb begin
        start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
        wr_acc   = wr_en_q && mem.ctrl_ready;
        rd_acc   = rd_en_q && mem.ctrl_ready;
        chk_vld  = mem.o_user_data_valid && (out_q != '0);
        spurious = mem.o_user_data_valid && (out_q == '0);
        mismatch = chk_vld && (mem.o_user_data != chk_word);
        last_chk = chk_vld && (chk_idx_q == LAST_IDX);
        out_d    = out_q + OW'(rd_acc) - OW'(chk_vld);
        issued_d = issued_q + CW'(rd_acc);
        abort_d  = abort_q || (mismatch && stop_on_error);
    end

    // Two generators replay the same sequence: one paces write data, the other paces expected read data.
    ddr3_traffic_checker_pattern_gen #(.DQ(DQ_BITWIDTH)) u_cmd_gen (
        .clk(clk), .rst(reset), .load_i(start_ok), .advance_i(wr_acc),
        .mode_i(pattern_e'(mode)), .seed_i(seed), .word_o(cmd_word)
    );

    ddr3_traffic_checker_pattern_gen #(.DQ(DQ_BITWIDTH)) u_chk_gen (
        .clk(clk), .rst(reset), .load_i(start_ok), .advance_i(chk_vld),
        .mode_i(pattern_e'(mode)), .seed_i(seed), .word_o(chk_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            proto_q     <= 1'b0;
            abort_q     <= 1'b0;
            base_q      <= '0;
            addr_q      <= '0;
            chk_addr_q  <= '0;
            first_err_q <= '0;
            issued_q    <= '0;
            chk_idx_q   <= '0;
            out_q       <= '0;
            err_q       <= '0;
        end else begin
            if (spurious) proto_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q     <= ST_WRITE;
                        wr_en_q     <= 1'b1;
                        rd_en_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        proto_q     <= 1'b0;
                        abort_q     <= 1'b0;
                        err_q       <= '0;
                        first_err_q <= '0;
                        base_q      <= base_address;
                        addr_q      <= base_address;
                        chk_addr_q  <= base_address;
                        issued_q    <= '0;
                        chk_idx_q   <= '0;
                        out_q       <= '0;
                    end
                end
                ST_WRITE: begin
                    if (wr_acc) begin
                        addr_q   <= addr_q + A_ONE;
                        issued_q <= issued_q + C_ONE;
                        if (issued_q == LAST_IDX) begin
                            state_q  <= ST_READ;
                            wr_en_q  <= 1'b0;
                            rd_en_q  <= 1'b1;
                            addr_q   <= base_q;
                            issued_q <= '0;
                        end
                    end
                end
                ST_READ: begin
                    issued_q <= issued_d;
                    out_q    <= out_d;
                    abort_q  <= abort_d;
                    if (rd_acc) addr_q <= addr_q + A_ONE;
                    if (chk_vld) begin
                        chk_idx_q  <= chk_idx_q + C_ONE;
                        chk_addr_q <= chk_addr_q + A_ONE;
                    end
                    if (mismatch) begin
                        if (err_q != '1) err_q <= err_q + E_ONE;
                        if (err_q == '0) first_err_q <= chk_addr_q;
                    end
                    // An aborted run only ends once every issued read has come back.
                    if (last_chk || (abort_d && out_d == '0)) begin
                        state_q <= ST_DONE;
                        rd_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                    end else begin
                        rd_en_q <= !abort_d && (issued_d < N_WORDS) && (out_d < MAX_OUT);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem.write_enable        = wr_en_q;
    assign mem.read_enable         = rd_en_q;
    assign mem.i_user_data_address = addr_q;
    assign mem.i_user_data         = cmd_word;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign pass                    = pass_q;
    assign error_count             = err_q;
    assign first_error_address     = first_err_q;
    assign protocol_error          = proto_q;
    assign main_state              = state_q;
endmodule
